// File: rtl/uart_fifo_mon_pkg.sv
// Shared constants and types for the UART FIFO occupancy monitor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_fifo_mon_pkg;

    localparam int DEF_DEPTH = 16;
    localparam int DEF_CNT_W = 8;

    // Occupancy width able to hold every value 0..depth inclusive.
    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // How a channel's occupancy moves this cycle.
    // OVF/UDF hold occupancy because the strobe had no effect.
    typedef enum logic [2:0] {
        HOLD,
        INC,
        DEC,
        OVF,
        UDF
    } upd_e;

endpackage

// File: rtl/uart_fifo_occ_chan.sv
// One FIFO's occupancy tracker: occupancy, peak, watermark crossings, sticky ovf/udf.
// Latency: a strobe in cycle N is visible on every output after edge N+1.
// Backpressure: none; the monitor only observes and never stalls the tapped FIFO.
module uart_fifo_occ_chan
    import uart_fifo_mon_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = DEF_CNT_W,
    parameter int OCC_W = occ_w(DEPTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [OCC_W-1:0] i_hi_wm,
    input  logic             i_clear,
    output logic [OCC_W-1:0] o_occ,
    output logic [OCC_W-1:0] o_peak,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_above_wm,
    output logic [CNT_W-1:0] o_wm_cross_cnt,
    output logic             o_ovf,
    output logic             o_udf
);

    localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [OCC_W-1:0] r_occ;
    logic [OCC_W-1:0] r_peak;
    logic             r_above;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    logic             r_udf;

    logic             w_full;
    logic             w_empty;
    upd_e             w_upd;
    logic             w_set_ovf;
    logic             w_set_udf;
    logic [OCC_W-1:0] w_occ_next;
    logic [OCC_W-1:0] w_peak_next;
    logic             w_above_next;
    logic             w_rise;

    assign w_full  = (r_occ == OCC_MAX);
    assign w_empty = (r_occ == '0);

    // Classify the strobe pair; push+pop on empty grows by one but still flags the pop.
    always_comb begin
        w_upd     = HOLD;
        w_set_udf = i_pop && w_empty;
        case ({i_push, i_pop})
            2'b10:   w_upd = w_full  ? OVF : INC;
            2'b01:   w_upd = w_empty ? UDF : DEC;
            2'b11:   w_upd = w_empty ? INC : HOLD;
            default: w_upd = HOLD;
        endcase
        w_set_ovf = (w_upd == OVF);
    end

    // Next occupancy, peak and watermark state; INC/DEC are only chosen inside 0..DEPTH.
    always_comb begin
        w_occ_next = r_occ;
        case (w_upd)
            INC:     w_occ_next = r_occ + 1'b1;
            DEC:     w_occ_next = r_occ - 1'b1;
            default: w_occ_next = r_occ;
        endcase
        if (i_clear || (w_occ_next > r_peak)) begin
            w_peak_next = w_occ_next;
        end else begin
            w_peak_next = r_peak;
        end
        w_above_next = (i_hi_wm != '0) && (w_occ_next >= i_hi_wm);
        w_rise       = w_above_next && !r_above;
    end

    // State registers; clear restarts the statistics but a same-cycle event still lands.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_occ   <= '0;
            r_peak  <= '0;
            r_above <= 1'b0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            r_occ   <= w_occ_next;
            r_peak  <= w_peak_next;
            r_above <= w_above_next;
            r_ovf   <= (r_ovf && !i_clear) || w_set_ovf;
            r_udf   <= (r_udf && !i_clear) || w_set_udf;
            if (i_clear) begin
                r_cnt <= w_rise ? CNT_W'(1) : '0;
            end else if (w_rise && (r_cnt != CNT_MAX)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_occ          = r_occ;
    assign o_peak         = r_peak;
    assign o_full         = w_full;
    assign o_empty        = w_empty;
    assign o_above_wm     = r_above;
    assign o_wm_cross_cnt = r_cnt;
    assign o_ovf          = r_ovf;
    assign o_udf          = r_udf;

endmodule

// File: rtl/uart_fifo_occ_monitor.sv
// White-box occupancy monitor for NUM_CH UART FIFOs (ch0 = tx, ch1 = rx), feeding coverage/assertions.
// Latency: push/pop/clear in cycle N is reflected on all outputs after edge N+1.
// Backpressure: none; strobes are tapped passively and never stalled.
module uart_fifo_occ_monitor
    import uart_fifo_mon_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int OCC_W  = occ_w(DEPTH),
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [NUM_CH-1:0]       push,
    input  logic [NUM_CH-1:0]       pop,
    input  logic [NUM_CH*OCC_W-1:0] hi_wm,
    input  logic                    clear,
    output logic [NUM_CH*OCC_W-1:0] occ,
    output logic [NUM_CH*OCC_W-1:0] peak,
    output logic [NUM_CH-1:0]       full,
    output logic [NUM_CH-1:0]       empty,
    output logic [NUM_CH-1:0]       above_wm,
    output logic [NUM_CH*CNT_W-1:0] wm_cross_cnt,
    output logic [NUM_CH-1:0]       ovf,
    output logic [NUM_CH-1:0]       udf
);

    // One independent tracker per channel, packed onto the flattened buses.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        uart_fifo_occ_chan #(
            .DEPTH (DEPTH),
            .CNT_W (CNT_W),
            .OCC_W (OCC_W)
        ) u_chan (
            .clock          (clock),
            .reset_n        (reset_n),
            .i_push         (push[g]),
            .i_pop          (pop[g]),
            .i_hi_wm        (hi_wm[g*OCC_W +: OCC_W]),
            .i_clear        (clear),
            .o_occ          (occ[g*OCC_W +: OCC_W]),
            .o_peak         (peak[g*OCC_W +: OCC_W]),
            .o_full         (full[g]),
            .o_empty        (empty[g]),
            .o_above_wm     (above_wm[g]),
            .o_wm_cross_cnt (wm_cross_cnt[g*CNT_W +: CNT_W]),
            .o_ovf          (ovf[g]),
            .o_udf          (udf[g])
        );
    end

endmodule
